// File: rtl/alu_mult_sequencer_if.sv
// Handshake and ALU-sharing bus between the multiply sequencer and its environment.
// The slave modport is the sequencer; the master modport is the requester/ALU/arbiter side.
interface alu_mult_sequencer_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_command;
  logic [31:0] alu_result;
  logic        alu_carryout;

  modport slave (
    input  start, multiplicand, multiplier, alu_gnt, alu_result, alu_carryout,
    output busy, done, product, alu_req, alu_a, alu_b, alu_command
  );
  modport master (
    output start, multiplicand, multiplier, alu_gnt, alu_result, alu_carryout,
    input  busy, done, product, alu_req, alu_a, alu_b, alu_command
  );
endinterface

// File: rtl/alu_mult_sequencer.sv
// 32x32->64 unsigned shift-add multiplier that borrows the shared ALU as its adder.
// One granted ALU cycle per multiplier bit; the grant may stall any iteration.
module alu_mult_sequencer (
  input  logic                  clk,
  input  logic                  reset_n,
  alu_mult_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] product_q, product_d;
  logic        busy_q, busy_d, done_q, done_d, req_q, req_d;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    req_d     = req_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        req_d  = 1'b0;
        if (bus.start) begin
          mcand_d = bus.multiplicand;
          lo_d    = bus.multiplier;
          hi_d    = '0;
          count_d = '0;
          state_d = ITER;
          busy_d  = 1'b1;
          req_d   = 1'b1;
        end
      end
      ITER: begin
        if (bus.alu_gnt) begin
          // ALU sum is 33 bits wide with carry; shifting right by one drops it into hi[31]
          if (lo_q[0]) {hi_d, lo_d} = {bus.alu_carryout, bus.alu_result, lo_q[31:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
          count_d = count_q + 6'd1;
          if (count_q == 6'd31) begin
            product_d = {hi_d, lo_d};
            state_d   = DONE;
            done_d    = 1'b1;
            req_d     = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      req_q     <= req_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.product     = product_q;
  assign bus.alu_req     = req_q;
  assign bus.alu_a       = (state_q == ITER) ? hi_q    : '0;
  assign bus.alu_b       = (state_q == ITER) ? mcand_q : '0;
  assign bus.alu_command = 3'd0;
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Randomized bench for alu_mult_sequencer against an arithmetic reference model.
module tb_alu_mult_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_mult_sequencer_if bus ();

  alu_mult_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // shared ALU: plain 32-bit adder with carry out
  assign {bus.alu_carryout, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // after k granted steps the upper word holds (a * (b mod 2^k)) >> k
  function automatic logic [31:0] hi_after(input logic [31:0] a, input logic [31:0] b, input int k);
    logic [63:0] part;
    part = 64'(a) * (64'(b) & ((64'd1 << k) - 64'd1));
    return 32'(part >> k);
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall_n,
                        input bit restart, input string tag);
    int k = 0;
    int stalls = 0;
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = a; bus.multiplier = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.multiplicand = $urandom; bus.multiplier = $urandom;
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
      chk({tag, ".req"},  64'(bus.alu_req), 64'd1);
      chk({tag, ".alu_a"}, 64'(bus.alu_a), 64'(hi_after(a, b, k)));
      chk({tag, ".alu_b"}, 64'(bus.alu_b), 64'(a));
      if (stalls < stall_n && ($urandom_range(0, 3) == 0 || k >= 24)) begin
        bus.alu_gnt = 1'b0; stalls++;
      end else begin
        bus.alu_gnt = 1'b1; k++;
      end
      if (restart && cyc == 10) begin
        bus.start = 1'b1; bus.multiplicand = 32'd2; bus.multiplier = 32'd2;
      end else bus.start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.alu_gnt = 1'b1;
    chk({tag, ".done"}, 64'(bus.done), 64'd1);
    chk({tag, ".lat"}, 64'(cyc), 64'(33 + stall_n));
    chk({tag, ".prod"}, bus.product, 64'(a) * 64'(b));
    chk({tag, ".busy_dn"}, 64'(bus.busy), 64'd1);
    chk({tag, ".req_dn"}, 64'(bus.alu_req), 64'd0);
    if (restart) begin
      bus.start = 1'b1; bus.multiplicand = 32'd2; bus.multiplier = 32'd2;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ".done_off"}, 64'(bus.done), 64'd0);
    chk({tag, ".busy_off"}, 64'(bus.busy), 64'd0);
    chk({tag, ".prod_hold"}, bus.product, 64'(a) * 64'(b));
  endtask

  initial begin
    bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0; bus.alu_gnt = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.req", 64'(bus.alu_req), 64'd0);
    chk("rst.prod", bus.product, 64'd0);
    chk("rst.a", 64'(bus.alu_a), 64'd0);
    chk("rst.b", 64'(bus.alu_b), 64'd0);
    chk("rst.cmd", 64'(bus.alu_command), 64'd0);
    reset_n = 1'b1;

    run_op(32'd3, 32'd5, 0, 1'b0, "basic");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "full");
    run_op(32'd0, 32'h1234_5678, 0, 1'b0, "zero");
    run_op(32'h1234_5678, 32'd1, 0, 1'b0, "ident");
    run_op(32'h0000_FFFF, 32'h0001_0001, 5, 1'b0, "stall");
    run_op(32'd7, 32'd9, 0, 1'b1, "busy_start");
    run_op(32'd2, 32'd2, 0, 1'b0, "b2b");
    for (int i = 0; i < 6; i++)
      run_op($urandom, $urandom, int'($urandom_range(0, 6)), 1'b0, "rand");

    // reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'hDEAD_BEEF; bus.multiplier = 32'h10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("mrst.busy", 64'(bus.busy), 64'd0);
    chk("mrst.done", 64'(bus.done), 64'd0);
    chk("mrst.req", 64'(bus.alu_req), 64'd0);
    chk("mrst.a", 64'(bus.alu_a), 64'd0);
    chk("mrst.b", 64'(bus.alu_b), 64'd0);
    chk("mrst.prod", bus.product, 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("mrst.no_done", 64'(bus.done), 64'd0);
    end
    run_op(32'd6, 32'd7, 0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
